conv33_mac_sequencer: RTL
=========================

Name: conv33_mac_sequencer

Overview:
- Sequences one shared 6x6 unsigned multiplier across the 9 taps of a 3x3 convolution window.
- Accumulates the 9 products into a single window sum.
- Sits between the window/line-buffer stage (upstream valid/ready) and the output stage (downstream valid/ready).
- The multiplier is external, purely combinational, and driven through the mul_a/mul_b/mul_p ports.

Parameters:
- DATA_W, 6: pixel and weight width, unsigned.
- TAPS, 9: products per window.
- ACC_W, 16: accumulator and out_sum width. Must be >= 2*DATA_W + clog2(TAPS); 16 covers the worst case 9*63*63 = 35721.

Ports:
- clk  in  1: rising-edge clock.
- rst_n  in  1: asynchronous, active-low reset.
- in_valid  in  1: window operands are valid.
- in_ready  out  1: block can accept a window.
- pix_flat  in  TAPS*DATA_W: tap k occupies bits [k*DATA_W +: DATA_W].
- wgt_flat  in  TAPS*DATA_W: weights, same packing as pix_flat.
- mul_a  out  DATA_W: multiplier operand A (pixel).
- mul_b  out  DATA_W: multiplier operand B (weight).
- mul_p  in  2*DATA_W: multiplier product, combinational from mul_a/mul_b.
- out_valid  out  1: out_sum holds a completed window sum.
- out_ready  in  1: downstream accepts out_sum.
- out_sum  out  ACC_W: sum over k of pix[k]*wgt[k], modulo 2^ACC_W.
- busy  out  1: high in RUN or DONE.

Behaviour:
- FSM states: IDLE, RUN, DONE.
- Reset (rst_n low, asynchronous):
  - state=IDLE, idx=0, acc=0.
  - out_valid=0, out_sum=0, operand registers=0.
  - mul_a=0, mul_b=0, busy=0.
  - in_ready is combinational (state==IDLE), so it reads 1 during reset; no capture occurs while rst_n is low.
- IDLE:
  - in_ready=1; mul_a=mul_b=0.
  - On the edge with in_valid & in_ready: register pix_flat and wgt_flat, clear idx and acc, go to RUN.
  - Inputs are not sampled again until the next IDLE.
- RUN:
  - in_ready=0; mul_a=pix_reg[idx], mul_b=wgt_reg[idx] (combinational from registers).
  - Each edge: acc <= acc + zero-extended mul_p; idx <= idx+1.
  - When idx==TAPS-1: out_sum <= acc + mul_p, out_valid <= 1, go to DONE.
  - RUN lasts exactly TAPS cycles.
- DONE:
  - out_valid=1; out_sum and acc are held stable; mul_a=mul_b=0; in_ready=0.
  - On the edge with out_valid & out_ready: out_valid <= 0, go to IDLE. out_sum keeps its last value.
- Latency and throughput:
  - Acceptance edge E0; out_valid is high after edge E9 (TAPS edges later).
  - Minimum period is TAPS+2 cycles per window (IDLE, TAPS x RUN, DONE). There is no DONE->RUN bypass.
- Arithmetic: all unsigned; addition wraps modulo 2^ACC_W with no saturation or overflow flag.
- in_valid deasserting in RUN or DONE has no effect; inputs may change freely after acceptance.
- out_ready high in IDLE or RUN has no effect.
- Reset asserted mid-RUN or mid-DONE: the window is discarded and no out_valid pulse is produced. After release the block returns to IDLE with in_ready=1.
- mul_p is sampled only in RUN; its value in other states is ignored.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles with in_valid=1, then release.
  -> out_valid=0, out_sum=0, mul_a=mul_b=0, busy=0, in_ready=1.
  -> No capture during reset.
- Ramp window: pix all 1, wgt k=1..9.
  -> mul_b steps 1,2,...,9 on consecutive cycles; mul_a=1 throughout.
  -> out_valid rises 9 edges after acceptance with out_sum=45.
- Worst case: pix=wgt=63 on all taps.
  -> out_sum=35721, no wrap.
  -> Repeat with ACC_W=12: out_sum=35721 mod 4096 = 2953.
- Backpressure: out_ready=0 for 5 cycles after out_valid, with in_valid=1 and new operands presented.
  -> out_sum held, in_ready=0, new operands not captured.
  -> out_ready=1 gives a handshake; IDLE follows the next cycle.
- Reset mid-RUN: assert rst_n=0 while idx=4.
  -> Immediate IDLE, acc=0, out_valid never pulses.
  -> A following window (pix=2, wgt=3 all taps) gives out_sum=54.
- Back-to-back: in_valid and out_ready held high with windows A (all 1s) then B (pix=k, wgt=1).
  -> Results 9, then 36 (0+1+...+8).
  -> Acceptances spaced exactly 11 cycles apart.

Source files
------------

// File: rtl/conv33_mac_sequencer.sv
// Time-multiplexes one external combinational multiplier across the taps of a
// 3x3 convolution window and accumulates the products into one window sum.
//
// state | meaning
// IDLE  | waiting for a window; in_ready high, multiplier operands forced to 0
// RUN   | one tap per cycle through the shared multiplier, accumulating
// DONE  | out_sum valid, held until downstream handshake
module conv33_mac_sequencer #(
  parameter int DATA_W = 6,
  parameter int TAPS   = 9,
  parameter int ACC_W  = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [TAPS*DATA_W-1:0]   pix_flat,
  input  logic [TAPS*DATA_W-1:0]   wgt_flat,
  output logic [DATA_W-1:0]        mul_a,
  output logic [DATA_W-1:0]        mul_b,
  input  logic [2*DATA_W-1:0]      mul_p,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [ACC_W-1:0]         out_sum,
  output logic                     busy
);

  localparam int IDX_W = $clog2(TAPS);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                  state_q, state_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [ACC_W-1:0]        acc_q, acc_d;
  logic [ACC_W-1:0]        out_sum_q, out_sum_d;
  logic                    out_valid_q, out_valid_d;
  logic [TAPS*DATA_W-1:0]  pix_q, pix_d;
  logic [TAPS*DATA_W-1:0]  wgt_q, wgt_d;
  logic [DATA_W-1:0]       tap_pix, tap_wgt;
  logic [ACC_W-1:0]        acc_sum;

  // Explicit tap mux keeps out-of-range idx values from indexing past the vectors.
  always_comb begin
    tap_pix = '0;
    tap_wgt = '0;
    for (int k = 0; k < TAPS; k++) begin
      if (idx_q == IDX_W'(k)) begin
        tap_pix = pix_q[k*DATA_W +: DATA_W];
        tap_wgt = wgt_q[k*DATA_W +: DATA_W];
      end
    end
  end

  assign acc_sum = acc_q + ACC_W'(mul_p);

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    acc_d       = acc_q;
    out_sum_d   = out_sum_q;
    out_valid_d = out_valid_q;
    pix_d       = pix_q;
    wgt_d       = wgt_q;
    mul_a       = '0;
    mul_b       = '0;
    in_ready    = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          pix_d   = pix_flat;
          wgt_d   = wgt_flat;
          idx_d   = '0;
          acc_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        mul_a = tap_pix;
        mul_b = tap_wgt;
        acc_d = acc_sum;
        idx_d = idx_q + IDX_W'(1);
        if (idx_q == IDX_W'(TAPS-1)) begin
          out_sum_d   = acc_sum;
          out_valid_d = 1'b1;
          state_d     = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      acc_q       <= '0;
      out_sum_q   <= '0;
      out_valid_q <= 1'b0;
      pix_q       <= '0;
      wgt_q       <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      acc_q       <= acc_d;
      out_sum_q   <= out_sum_d;
      out_valid_q <= out_valid_d;
      pix_q       <= pix_d;
      wgt_q       <= wgt_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_sum   = out_sum_q;
  assign busy      = (state_q != IDLE);

endmodule
